ex_hazard_ctrl: RTL and testbench
=================================

Name: ex_hazard_ctrl

Overview:
- Pipeline hazard controller for the EX stage of the 5-stage RV32I core.
- Decides each cycle whether to hold IF/ID, insert a bubble into ID/EX, or flush after a taken branch.
- Registers the forwarding selects (fwd_t: NO_FWD / EX_MEM_FWD / MEM_WB_FWD) that the ALU operand muxes use during EX.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
FLUSH_CYCLES, 1, total cycles bubble_id_ex is held after a taken branch (legal range 1..7).
COUNT_W, 16, width of the stall and flush counters.

Ports:
clk  in  1  core clock; all state updates on rising edge.
reset_n  in  1  asynchronous active-low reset.
id_valid  in  1  ID holds a real instruction.
id_rs1  in  5  rs1 of the instruction in ID.
id_rs2  in  5  rs2 of the instruction in ID.
id_uses_rs1  in  1  ID instruction reads rs1.
id_uses_rs2  in  1  ID instruction reads rs2 (R/S/B types).
ex_valid  in  1  EX holds a real instruction.
ex_rd  in  5  reg_rd_id in ID/EX.
ex_reg_write  in  1  control.reg_write in ID/EX.
ex_mem_read  in  1  control.mem_read in ID/EX.
mem_valid  in  1  MEM holds a real instruction.
mem_rd  in  5  reg_rd_id in EX/MEM.
mem_reg_write  in  1  control.reg_write in EX/MEM.
branch_taken  in  1  taken branch resolved in EX this cycle.
stall_if_id  out  1  hold PC and IF/ID.
bubble_id_ex  out  1  load NOP control into ID/EX.
flush_if_id  out  1  replace IF/ID with NOP_INSTRUCTION.
fwd_a  out  2  fwd_t select for ALU operand A, valid during EX.
fwd_b  out  2  fwd_t select for ALU operand B, valid during EX.
state  out  2  FSM state: 0 RUN, 1 STALL, 2 FLUSH.
stall_count  out  COUNT_W  load-use stalls since reset, saturating.
flush_count  out  COUNT_W  taken-branch flushes since reset, saturating.

Behaviour:
Reset (asynchronous, on reset_n low):
- state=RUN; fwd_a=fwd_b=NO_FWD; both counters 0.
- Combinational outputs are 0 while in reset.
- Reset mid-flush or mid-stall aborts the sequence; the next cycle starts in RUN.

Load-use hazard (lu):
- lu = id_valid & ex_valid & ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).

Taken branch (br):
- br = branch_taken & ex_valid.

Combinational outputs:
- br has priority over lu: flush_if_id=1, bubble_id_ex=1, stall_if_id=0.
- In state FLUSH: bubble_id_ex=1, flush_if_id=1.
- Else if lu: stall_if_id=1, bubble_id_ex=1.
- Otherwise all three are 0.

FSM:
- RUN:
  - br & FLUSH_CYCLES>1 -> FLUSH, remaining counter loaded with FLUSH_CYCLES-2.
  - br & FLUSH_CYCLES==1 -> RUN.
  - else lu -> STALL.
  - else stay RUN.
- STALL (one cycle; the load has moved to MEM):
  - br -> handled as in RUN.
  - else lu -> STALL.
  - else -> RUN.
- FLUSH:
  - Decrement remaining each cycle; -> RUN when remaining==0.
  - branch_taken is ignored while in FLUSH (EX holds a bubble).

Forwarding registers (updated each edge):
- If bubble_id_ex or !id_valid: load NO_FWD.
- Else, per operand (A uses rs1 and id_uses_rs1; B uses rs2 and id_uses_rs2):
  - EX_MEM_FWD if ex_valid & ex_reg_write & ex_rd!=0 & rs==ex_rd.
  - Else MEM_WB_FWD if mem_valid & mem_reg_write & mem_rd!=0 & rs==mem_rd.
  - Else NO_FWD.
- EX_MEM_FWD has priority over MEM_WB_FWD (youngest producer wins).
- x0 never forwards.
- WB-to-ID same-cycle hazards are handled by register-file write-through, not by this block.

Counters:
- stall_count increments on each cycle where lu is asserted and br is not.
- flush_count increments on each cycle where br is asserted and state!=FLUSH.
- Both saturate at all-ones; no wrap.

Test Plan:
- Load-use: EX=lw rd=5 (mem_read, reg_write); ID=add rs1=5, rs2=6. Expect stall_if_id=1 and bubble_id_ex=1 for one cycle, state RUN->STALL->RUN, stall_count=1. Next cycle with mem_rd=5: fwd_a=MEM_WB_FWD, fwd_b=NO_FWD.
- Double producer: ex_rd=3 and mem_rd=3, both reg_write; ID reads rs1=rs2=3. Expect fwd_a=fwd_b=EX_MEM_FWD after the edge.
- x0: ex_rd=0 with reg_write, ID rs1=0. Expect fwd_a=NO_FWD and no stall, even when ex_mem_read=1.
- Branch vs load-use in the same cycle: branch_taken=1 plus an lu condition. Expect flush_if_id=1, bubble_id_ex=1, stall_if_id=0; flush_count=1, stall_count unchanged.
- FLUSH_CYCLES=3: one taken branch gives bubble_id_ex high for exactly 3 cycles and state RUN->FLUSH->FLUSH->RUN. branch_taken=1 on the 2nd cycle does not change flush_count.
- Saturation and reset: COUNT_W=2; 5 load-use stalls give stall_count=3. Assert reset_n=0 mid-FLUSH: state=RUN, counters 0, fwd=NO_FWD immediately, with no clock edge.

Source files
------------

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard control: load-use stall, taken-branch flush, registered forwarding selects.
// Latency: stall/bubble/flush are combinational in the decision cycle; fwd selects register one edge later.
// No backpressure: single-cycle decisions; the flush sequence runs to completion unless reset aborts it.
module ex_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int COUNT_W      = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               id_valid,
    input  logic [4:0]         id_rs1,
    input  logic [4:0]         id_rs2,
    input  logic               id_uses_rs1,
    input  logic               id_uses_rs2,
    input  logic               ex_valid,
    input  logic [4:0]         ex_rd,
    input  logic               ex_reg_write,
    input  logic               ex_mem_read,
    input  logic               mem_valid,
    input  logic [4:0]         mem_rd,
    input  logic               mem_reg_write,
    input  logic               branch_taken,
    output logic               stall_if_id,
    output logic               bubble_id_ex,
    output logic               flush_if_id,
    output logic [1:0]         fwd_a,
    output logic [1:0]         fwd_b,
    output logic [1:0]         state,
    output logic [COUNT_W-1:0] stall_count,
    output logic [COUNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        NO_FWD     = 2'd0,
        EX_MEM_FWD = 2'd1,
        MEM_WB_FWD = 2'd2
    } fwd_t;

    // The branch cycle itself is the first bubble, so FLUSH covers the remaining FLUSH_CYCLES-1.
    localparam logic [2:0] FLUSH_LOAD = (FLUSH_CYCLES > 1) ? 3'(FLUSH_CYCLES - 2) : 3'd0;
    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    state_t             state_q, state_d;
    logic [2:0]         rem_q, rem_d;
    fwd_t               fwd_a_q, fwd_a_d;
    fwd_t               fwd_b_q, fwd_b_d;
    logic [COUNT_W-1:0] stall_cnt_q;
    logic [COUNT_W-1:0] flush_cnt_q;

    logic lu;
    logic br;
    logic rs1_lu_hit;
    logic rs2_lu_hit;
    logic stall_c;
    logic bubble_c;
    logic flush_c;
    logic stall_inc;
    logic flush_inc;

    assign rs1_lu_hit = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_lu_hit = id_uses_rs2 && (id_rs2 == ex_rd);
    assign lu = id_valid && ex_valid && ex_mem_read && (ex_rd != 5'd0) && (rs1_lu_hit || rs2_lu_hit);
    assign br = branch_taken && ex_valid;

    always_comb begin
        stall_c  = 1'b0;
        bubble_c = 1'b0;
        flush_c  = 1'b0;
        if (state_q == FLUSH) begin
            bubble_c = 1'b1;
            flush_c  = 1'b1;
        end else if (br) begin
            bubble_c = 1'b1;
            flush_c  = 1'b1;
        end else if (lu) begin
            stall_c  = 1'b1;
            bubble_c = 1'b1;
        end
    end

    // Gate with reset so the pipeline sees quiet controls while held in reset.
    assign stall_if_id  = stall_c  && reset_n;
    assign bubble_id_ex = bubble_c && reset_n;
    assign flush_if_id  = flush_c  && reset_n;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        unique case (state_q)
            RUN, STALL: begin
                if (br) begin
                    if (FLUSH_CYCLES > 1) begin
                        state_d = FLUSH;
                        rem_d   = FLUSH_LOAD;
                    end else begin
                        state_d = RUN;
                    end
                end else if (lu) begin
                    state_d = STALL;
                end else begin
                    state_d = RUN;
                end
            end
            FLUSH: begin
                if (rem_q == 3'd0) begin
                    state_d = RUN;
                end else begin
                    rem_d = rem_q - 3'd1;
                end
            end
            default: begin
                state_d = RUN;
                rem_d   = 3'd0;
            end
        endcase
    end

    // Youngest producer (EX/MEM) wins; x0 is never a forwarding source.
    always_comb begin
        fwd_a_d = NO_FWD;
        fwd_b_d = NO_FWD;
        if (!bubble_c && id_valid) begin
            if (id_uses_rs1 && ex_valid && ex_reg_write && (ex_rd != 5'd0) && (id_rs1 == ex_rd)) begin
                fwd_a_d = EX_MEM_FWD;
            end else if (id_uses_rs1 && mem_valid && mem_reg_write && (mem_rd != 5'd0) && (id_rs1 == mem_rd)) begin
                fwd_a_d = MEM_WB_FWD;
            end
            if (id_uses_rs2 && ex_valid && ex_reg_write && (ex_rd != 5'd0) && (id_rs2 == ex_rd)) begin
                fwd_b_d = EX_MEM_FWD;
            end else if (id_uses_rs2 && mem_valid && mem_reg_write && (mem_rd != 5'd0) && (id_rs2 == mem_rd)) begin
                fwd_b_d = MEM_WB_FWD;
            end
        end
    end

    assign stall_inc = lu && !br;
    assign flush_inc = br && (state_q != FLUSH);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RUN;
            rem_q       <= 3'd0;
            fwd_a_q     <= NO_FWD;
            fwd_b_q     <= NO_FWD;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
            if (stall_inc && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (flush_inc && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign state       = state_q;
    assign fwd_a       = fwd_a_q;
    assign fwd_b       = fwd_b_q;
    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Bench for ex_hazard_ctrl: two instances (FLUSH_CYCLES=1/COUNT_W=16 and FLUSH_CYCLES=3/COUNT_W=2)
// share stimulus; a cycle-level reference model predicts every output of both.
module tb_ex_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       id_valid, id_uses_rs1, id_uses_rs2;
    logic [4:0] id_rs1, id_rs2;
    logic       ex_valid, ex_reg_write, ex_mem_read;
    logic [4:0] ex_rd;
    logic       mem_valid, mem_reg_write;
    logic [4:0] mem_rd;
    logic       branch_taken;

    logic       stall_o [2];
    logic       bub_o   [2];
    logic       fl_o    [2];
    logic [1:0] st_o    [2];
    logic [1:0] fa_o    [2];
    logic [1:0] fb_o    [2];
    logic [15:0] sc0, fc0;
    logic [1:0]  sc1, fc1;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: cycles of FLUSH left, whether a stall cycle is in progress, counters, fwd selects.
    int m_fl [2];
    int m_stl[2];
    int m_sc [2];
    int m_fc [2];
    int m_fa [2];
    int m_fb [2];

    always #5 clk = ~clk;

    ex_hazard_ctrl #(.FLUSH_CYCLES(1), .COUNT_W(16)) u_dut0 (
        .clk(clk), .reset_n(reset_n),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .branch_taken(branch_taken),
        .stall_if_id(stall_o[0]), .bubble_id_ex(bub_o[0]), .flush_if_id(fl_o[0]),
        .fwd_a(fa_o[0]), .fwd_b(fb_o[0]), .state(st_o[0]),
        .stall_count(sc0), .flush_count(fc0)
    );

    ex_hazard_ctrl #(.FLUSH_CYCLES(3), .COUNT_W(2)) u_dut1 (
        .clk(clk), .reset_n(reset_n),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .branch_taken(branch_taken),
        .stall_if_id(stall_o[1]), .bubble_id_ex(bub_o[1]), .flush_if_id(fl_o[1]),
        .fwd_a(fa_o[1]), .fwd_b(fb_o[1]), .state(st_o[1]),
        .stall_count(sc1), .flush_count(fc1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int flush_len(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int cnt_max(input int i);
        return (i == 0) ? 65535 : 3;
    endfunction

    function automatic logic [31:0] scnt(input int i);
        return (i == 0) ? {16'd0, sc0} : {30'd0, sc1};
    endfunction

    function automatic logic [31:0] fcnt(input int i);
        return (i == 0) ? {16'd0, fc0} : {30'd0, fc1};
    endfunction

    // 0 none, 1 from EX/MEM, 2 from MEM/WB
    function automatic int exp_fwd(input bit uses, input int rs);
        if (!uses || rs == 0) return 0;
        if (ex_valid && ex_reg_write && rs == int'(ex_rd)) return 1;
        if (mem_valid && mem_reg_write && rs == int'(mem_rd)) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_fl[i] = 0; m_stl[i] = 0; m_sc[i] = 0; m_fc[i] = 0; m_fa[i] = 0; m_fb[i] = 0;
        end
    endtask

    // Called just after a rising edge: checks all outputs mid-cycle, advances the model, crosses one edge.
    task automatic cycle();
        bit lu, br, inf, bub;
        int e_st;
        #2;
        lu = id_valid && ex_valid && ex_mem_read && ex_rd != 0 &&
             ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
        br = branch_taken && ex_valid;
        for (int i = 0; i < 2; i++) begin
            inf  = m_fl[i] > 0;
            e_st = inf ? 2 : (m_stl[i] != 0 ? 1 : 0);
            bub  = reset_n && (inf || br || lu);
            check($sformatf("state[%0d]", i), st_o[i], e_st);
            check($sformatf("fwd_a[%0d]", i), fa_o[i], m_fa[i]);
            check($sformatf("fwd_b[%0d]", i), fb_o[i], m_fb[i]);
            check($sformatf("stall_count[%0d]", i), scnt(i), m_sc[i]);
            check($sformatf("flush_count[%0d]", i), fcnt(i), m_fc[i]);
            check($sformatf("bubble[%0d]", i), bub_o[i], bub);
            check($sformatf("flush_if_id[%0d]", i), fl_o[i], reset_n && (inf || br));
            check($sformatf("stall_if_id[%0d]", i), stall_o[i], reset_n && !inf && !br && lu);
            if (!reset_n) begin
                m_fl[i] = 0; m_stl[i] = 0; m_sc[i] = 0; m_fc[i] = 0; m_fa[i] = 0; m_fb[i] = 0;
            end else begin
                m_fa[i] = (bub || !id_valid) ? 0 : exp_fwd(id_uses_rs1, int'(id_rs1));
                m_fb[i] = (bub || !id_valid) ? 0 : exp_fwd(id_uses_rs2, int'(id_rs2));
                if (lu && !br && m_sc[i] < cnt_max(i)) m_sc[i]++;
                if (br && !inf && m_fc[i] < cnt_max(i)) m_fc[i]++;
                if (inf) begin
                    m_fl[i]--;
                    m_stl[i] = 0;
                end else if (br) begin
                    m_fl[i]  = flush_len(i) - 1;
                    m_stl[i] = 0;
                end else begin
                    m_stl[i] = lu ? 1 : 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        ex_valid = 0; ex_rd = 0; ex_reg_write = 0; ex_mem_read = 0;
        mem_valid = 0; mem_rd = 0; mem_reg_write = 0; branch_taken = 0;
    endtask

    // EX holds lw x5; ID holds add rs1=x5, rs2=x6.
    task automatic set_load_use();
        idle();
        ex_valid = 1; ex_rd = 5; ex_mem_read = 1; ex_reg_write = 1;
        id_valid = 1; id_rs1 = 5; id_rs2 = 6; id_uses_rs1 = 1; id_uses_rs2 = 1;
    endtask

    task automatic rnd();
        id_valid      = ($urandom_range(0, 7) != 0);
        id_rs1        = 5'($urandom_range(0, 3));
        id_rs2        = 5'($urandom_range(0, 3));
        id_uses_rs1   = 1'($urandom);
        id_uses_rs2   = 1'($urandom);
        ex_valid      = ($urandom_range(0, 5) != 0);
        ex_rd         = 5'($urandom_range(0, 3));
        ex_reg_write  = 1'($urandom);
        ex_mem_read   = 1'($urandom);
        mem_valid     = 1'($urandom);
        mem_rd        = 5'($urandom_range(0, 3));
        mem_reg_write = 1'($urandom);
        branch_taken  = ($urandom_range(0, 7) == 0);
    endtask

    initial begin
        reset_n = 0;
        idle();
        model_reset();
        #2;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_state[%0d]", i), st_o[i], 0);
            check($sformatf("rst_fwd_a[%0d]", i), fa_o[i], 0);
            check($sformatf("rst_stall_count[%0d]", i), scnt(i), 0);
        end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1;
        cycle();

        // load-use: one stall cycle, then MEM/WB forwarding of x5 to operand A
        set_load_use();
        cycle();
        ex_valid = 0; ex_mem_read = 0; ex_reg_write = 0;
        mem_valid = 1; mem_rd = 5; mem_reg_write = 1;
        cycle();
        check("lu_fwd_a", fa_o[0], 2);
        check("lu_fwd_b", fb_o[0], 0);
        check("lu_state_back", st_o[0], 0);
        check("lu_stall_count", scnt(0), 1);

        // both EX and MEM produce x3: youngest wins
        idle();
        ex_valid = 1; ex_rd = 3; ex_reg_write = 1;
        mem_valid = 1; mem_rd = 3; mem_reg_write = 1;
        id_valid = 1; id_rs1 = 3; id_rs2 = 3; id_uses_rs1 = 1; id_uses_rs2 = 1;
        cycle();
        check("dbl_fwd_a", fa_o[0], 1);
        check("dbl_fwd_b", fb_o[0], 1);

        // x0 never stalls or forwards, even from a load
        idle();
        ex_valid = 1; ex_rd = 0; ex_reg_write = 1; ex_mem_read = 1;
        id_valid = 1; id_rs1 = 0; id_uses_rs1 = 1;
        cycle();
        check("x0_fwd_a", fa_o[0], 0);
        check("x0_stall_count", scnt(0), 1);

        // branch and load-use together: branch wins
        set_load_use();
        branch_taken = 1;
        cycle();
        check("br_lu_flush_count", fcnt(0), 1);
        check("br_lu_stall_count", scnt(0), 1);
        idle();
        repeat (3) cycle();

        // FLUSH_CYCLES=3 sequence with a second branch arriving mid-flush
        ex_valid = 1; branch_taken = 1;
        cycle();
        cycle();
        idle();
        cycle();
        cycle();
        check("flush3_flush_count", fcnt(1), 2);
        check("flush1_flush_count", fcnt(0), 3);

        // saturation of the 2-bit counter
        for (int k = 0; k < 5; k++) begin
            set_load_use();
            cycle();
            idle();
            cycle();
        end
        check("sat_stall_count2", scnt(1), 3);
        check("stall_count16", scnt(0), 6);

        // asynchronous reset in the middle of a flush
        ex_valid = 1; branch_taken = 1;
        cycle();
        check("pre_rst_state", st_o[1], 2);
        set_load_use();
        branch_taken = 1;
        reset_n = 0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("arst_state[%0d]", i), st_o[i], 0);
            check($sformatf("arst_stall_count[%0d]", i), scnt(i), 0);
            check($sformatf("arst_flush_count[%0d]", i), fcnt(i), 0);
            check($sformatf("arst_fwd_a[%0d]", i), fa_o[i], 0);
            check($sformatf("arst_fwd_b[%0d]", i), fb_o[i], 0);
            check($sformatf("arst_bubble[%0d]", i), bub_o[i], 0);
            check($sformatf("arst_flush[%0d]", i), fl_o[i], 0);
            check($sformatf("arst_stall[%0d]", i), stall_o[i], 0);
        end
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1;
        idle();
        cycle();

        for (int n = 0; n < 1500; n++) begin
            rnd();
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
